// File: rtl/game_pkg.sv
// Shared types and constants for the three-piece tic-tac-toe board logic.
// Cell codes, board geometry, win-line table and the line-detection helper.
package game_pkg;

  localparam int NUM_CELLS  = 9;
  localparam int MAX_PIECES = 3;

  typedef logic [1:0] cell_t;
  typedef cell_t [NUM_CELLS-1:0] board_t;
  typedef enum logic {PLAYER_X = 1'b0, PLAYER_O = 1'b1} player_t;

  localparam cell_t CELL_EMPTY = 2'b00;
  localparam cell_t CELL_X     = 2'b10;
  localparam cell_t CELL_O     = 2'b01;

  // Rows, columns, then the two diagonals; each entry is a triple of cell indices.
  localparam logic [7:0][2:0][3:0] WIN_LINES = {
    {4'd2, 4'd4, 4'd6},
    {4'd0, 4'd4, 4'd8},
    {4'd2, 4'd5, 4'd8},
    {4'd1, 4'd4, 4'd7},
    {4'd0, 4'd3, 4'd6},
    {4'd6, 4'd7, 4'd8},
    {4'd3, 4'd4, 4'd5},
    {4'd0, 4'd1, 4'd2}
  };

  function automatic cell_t player_code(input player_t p);
    return (p == PLAYER_O) ? CELL_O : CELL_X;
  endfunction

  function automatic logic has_line(input board_t b, input cell_t code);
    logic hit;
    hit = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if (b[WIN_LINES[l][0]] == code && b[WIN_LINES[l][1]] == code &&
          b[WIN_LINES[l][2]] == code)
        hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/piece_fifo.sv
// Circular queue of cell indices for one player's placed pieces; head is the oldest.
// Push and pop in the same cycle keep the count; updates land on the next edge.
module piece_fifo #(
  parameter int DEPTH = 3,
  parameter int IW    = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [IW-1:0] push_idx,
  input  logic          pop,
  output logic [IW-1:0] head_idx,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // When full, tail equals head, so a simultaneous push overwrites the entry being popped.
      if (push) begin
        mem[tail] <= push_idx;
        tail      <= bump(tail);
      end
      if (pop) head <= bump(head);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_idx = mem[head];
  assign full     = (count == CW'(DEPTH));

endmodule

// File: rtl/piece_eliminator.sv
// Board owner: applies committed moves, evicts each player's oldest piece past MAX_PIECES, detects wins.
// One-cycle registered latency; no backpressure, a request may arrive every cycle.
module piece_eliminator #(
  parameter int NUM_CELLS  = game_pkg::NUM_CELLS,
  parameter int MAX_PIECES = game_pkg::MAX_PIECES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mv_valid,
  input  logic [3:0] mv_cell,
  input  logic       mv_player,
  output logic [1:0] a0,
  output logic [1:0] a1,
  output logic [1:0] a2,
  output logic [1:0] a3,
  output logic [1:0] a4,
  output logic [1:0] a5,
  output logic [1:0] a6,
  output logic [1:0] a7,
  output logic [1:0] a8,
  output logic       turn,
  output logic       hint_valid,
  output logic [3:0] hint_cell,
  output logic       mv_ack,
  output logic       mv_err,
  output logic [1:0] winner,
  output logic       game_over
);
  import game_pkg::*;

  localparam int CW = $clog2(MAX_PIECES + 1);

  board_t        board;
  board_t        board_nxt;
  player_t       mover;
  cell_t         mover_code;
  logic          cell_ok;
  logic          cell_free;
  logic          accept;
  logic          win;
  logic          push_x, push_o, pop_x, pop_o;
  logic          full_x, full_o;
  logic [3:0]    head_x, head_o;
  logic [CW-1:0] count_x, count_o;
  logic          mover_full;
  logic [3:0]    mover_head;
  logic [CW-1:0] opp_count;
  logic [3:0]    opp_head;

  assign mover      = player_t'(mv_player);
  assign mover_code = player_code(mover);
  assign cell_ok    = (mv_cell < 4'(NUM_CELLS));

  always_comb begin
    cell_free = 1'b0;
    if (cell_ok) cell_free = (board[mv_cell] == CELL_EMPTY);
  end

  // The mover's own oldest piece still blocks its cell: occupancy is judged before eviction.
  assign accept = mv_valid && cell_ok && cell_free && (mv_player == turn) && !game_over;

  assign push_x = accept && (mover == PLAYER_X);
  assign push_o = accept && (mover == PLAYER_O);
  assign pop_x  = push_x && full_x;
  assign pop_o  = push_o && full_o;

  assign mover_full = (mover == PLAYER_O) ? full_o : full_x;
  assign mover_head = (mover == PLAYER_O) ? head_o : head_x;
  assign opp_count  = (mover == PLAYER_O) ? count_x : count_o;
  assign opp_head   = (mover == PLAYER_O) ? head_x : head_o;

  piece_fifo #(.DEPTH(MAX_PIECES), .IW(4)) u_fifo_x (
    .clk(clk), .rst(rst), .push(push_x), .push_idx(mv_cell), .pop(pop_x),
    .head_idx(head_x), .count(count_x), .full(full_x)
  );

  piece_fifo #(.DEPTH(MAX_PIECES), .IW(4)) u_fifo_o (
    .clk(clk), .rst(rst), .push(push_o), .push_idx(mv_cell), .pop(pop_o),
    .head_idx(head_o), .count(count_o), .full(full_o)
  );

  always_comb begin
    board_nxt = board;
    if (accept) begin
      board_nxt[mv_cell] = mover_code;
      if (mover_full) board_nxt[mover_head] = CELL_EMPTY;
    end
  end

  assign win = has_line(board_nxt, mover_code);

  always_ff @(posedge clk) begin
    if (!rst) begin
      board      <= '0;
      turn       <= 1'b0;
      hint_valid <= 1'b0;
      hint_cell  <= 4'd0;
      mv_ack     <= 1'b0;
      mv_err     <= 1'b0;
      winner     <= CELL_EMPTY;
      game_over  <= 1'b0;
    end else begin
      mv_ack <= accept;
      mv_err <= mv_valid && !accept;
      if (accept) begin
        board <= board_nxt;
        turn  <= ~turn;
        // The opponent's queue is untouched by this move, so its state now is its state next cycle.
        hint_valid <= (opp_count == CW'(MAX_PIECES));
        hint_cell  <= (opp_count == CW'(MAX_PIECES)) ? opp_head : 4'd0;
        if (win) begin
          winner    <= mover_code;
          game_over <= 1'b1;
        end
      end
    end
  end

  assign a0 = board[0];
  assign a1 = board[1];
  assign a2 = board[2];
  assign a3 = board[3];
  assign a4 = board[4];
  assign a5 = board[5];
  assign a6 = board[6];
  assign a7 = board[7];
  assign a8 = board[8];

endmodule

// File: tb/tb_piece_eliminator.sv
// Directed bench for piece_eliminator: hand-computed boards, hints, win latching and reset priority.
module tb_piece_eliminator;

  localparam logic PX = 1'b0;
  localparam logic PO = 1'b1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mv_valid = 1'b0;
  logic [3:0] mv_cell = 4'd0;
  logic       mv_player = 1'b0;
  logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
  logic       turn, hint_valid, mv_ack, mv_err, game_over;
  logic [3:0] hint_cell;
  logic [1:0] winner;
  logic [17:0] brd;

  int n_checks = 0;
  int n_pass   = 0;

  assign brd = {a8, a7, a6, a5, a4, a3, a2, a1, a0};

  always #5 clk = ~clk;

  piece_eliminator dut (
    .clk(clk), .rst(rst), .mv_valid(mv_valid), .mv_cell(mv_cell), .mv_player(mv_player),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8),
    .turn(turn), .hint_valid(hint_valid), .hint_cell(hint_cell),
    .mv_ack(mv_ack), .mv_err(mv_err), .winner(winner), .game_over(game_over)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Build the packed a8..a0 image from X and O occupancy masks (X = 10, O = 01).
  function automatic logic [17:0] board_of(input logic [8:0] xm, input logic [8:0] om);
    logic [17:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      r[2*i+1] = xm[i];
      r[2*i]   = om[i];
    end
    return r;
  endfunction

  function automatic int pieces_of(input logic [17:0] b, input logic [1:0] code);
    int n;
    n = 0;
    for (int i = 0; i < 9; i++) if (b[2*i +: 2] == code) n++;
    return n;
  endfunction

  task automatic move(input logic p, input logic [3:0] c);
    @(negedge clk);
    mv_valid  = 1'b1;
    mv_player = p;
    mv_cell   = c;
    @(posedge clk);
    #1;
    mv_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_board"},  32'(brd), 32'h0);
    check({tag, "_turn"},   32'(turn), 32'h0);
    check({tag, "_hintv"},  32'(hint_valid), 32'h0);
    check({tag, "_hintc"},  32'(hint_cell), 32'h0);
    check({tag, "_ack"},    32'(mv_ack), 32'h0);
    check({tag, "_err"},    32'(mv_err), 32'h0);
    check({tag, "_winner"}, 32'(winner), 32'h0);
    check({tag, "_gover"},  32'(game_over), 32'h0);
  endtask

  int xs [4] = '{0, 1, 5, 6};
  int os [4] = '{2, 3, 7, 8};
  int acks;
  int errs;
  int max_x;
  int max_o;

  initial begin
    // Reset state, then the first two placements.
    do_reset();
    check_reset_state("rst");
    move(PX, 4'd4);
    check("x4_ack", 32'(mv_ack), 32'h1);
    check("x4_err", 32'(mv_err), 32'h0);
    check("x4_a4",  32'(a4), 32'h2);
    check("x4_turn", 32'(turn), 32'h1);
    move(PO, 4'd0);
    check("o0_ack", 32'(mv_ack), 32'h1);
    check("o0_a0",  32'(a0), 32'h1);
    check("o0_turn", 32'(turn), 32'h0);
    check("o0_hintv", 32'(hint_valid), 32'h0);
    idle();
    check("idle_ack", 32'(mv_ack), 32'h0);
    check("idle_err", 32'(mv_err), 32'h0);

    // Hint and oldest-piece eviction.
    do_reset();
    move(PX, 4'd0); move(PO, 4'd3); move(PX, 4'd1);
    move(PO, 4'd7); move(PX, 4'd5); move(PO, 4'd4);
    check("h_hintv", 32'(hint_valid), 32'h1);
    check("h_hintc", 32'(hint_cell), 32'h0);
    check("h_turn",  32'(turn), 32'h0);
    move(PX, 4'd6);
    check("ev_ack",   32'(mv_ack), 32'h1);
    check("ev_board", 32'(brd), 32'(board_of(9'b001100010, 9'b010011000)));
    check("ev_hintv", 32'(hint_valid), 32'h1);
    check("ev_hintc", 32'(hint_cell), 32'h3);
    check("ev_winner", 32'(winner), 32'h0);

    // Rejections: wrong player, own oldest cell, out-of-range cell.
    move(PX, 4'd2);
    check("wp_err", 32'(mv_err), 32'h1);
    check("wp_ack", 32'(mv_ack), 32'h0);
    check("wp_board", 32'(brd), 32'(board_of(9'b001100010, 9'b010011000)));
    move(PO, 4'd8);
    check("o8_ack",   32'(mv_ack), 32'h1);
    check("o8_board", 32'(brd), 32'(board_of(9'b001100010, 9'b110010000)));
    check("o8_hintc", 32'(hint_cell), 32'h1);
    move(PX, 4'd1);
    check("own_err",   32'(mv_err), 32'h1);
    check("own_board", 32'(brd), 32'(board_of(9'b001100010, 9'b110010000)));
    move(PX, 4'd9);
    check("oor_err",   32'(mv_err), 32'h1);
    check("oor_board", 32'(brd), 32'(board_of(9'b001100010, 9'b110010000)));
    check("oor_turn",  32'(turn), 32'h0);

    // The pre-eviction board would hold row 0-1-2; after eviction it does not.
    do_reset();
    move(PX, 4'd0); move(PO, 4'd3); move(PX, 4'd1);
    move(PO, 4'd7); move(PX, 4'd5); move(PO, 4'd4);
    move(PX, 4'd2);
    check("nw_ack",    32'(mv_ack), 32'h1);
    check("nw_winner", 32'(winner), 32'h0);
    check("nw_gover",  32'(game_over), 32'h0);
    check("nw_board",  32'(brd), 32'(board_of(9'b000100110, 9'b010011000)));

    // Plain row win, then moves are refused.
    do_reset();
    move(PX, 4'd0); move(PO, 4'd3); move(PX, 4'd1); move(PO, 4'd4); move(PX, 4'd2);
    check("row_winner", 32'(winner), 32'h2);
    check("row_gover",  32'(game_over), 32'h1);
    move(PO, 4'd5);
    check("go_err",    32'(mv_err), 32'h1);
    check("go_winner", 32'(winner), 32'h2);
    check("go_a5",     32'(a5), 32'h0);

    // Diagonal 2-4-6 completed by the move that evicts X's piece on 0.
    do_reset();
    move(PX, 4'd0); move(PO, 4'd1); move(PX, 4'd2); move(PO, 4'd3); move(PX, 4'd4);
    check("d_pre_winner", 32'(winner), 32'h0);
    move(PO, 4'd5); move(PX, 4'd6);
    check("d_winner", 32'(winner), 32'h2);
    check("d_gover",  32'(game_over), 32'h1);
    check("d_a0",     32'(a0), 32'h0);
    check("d_a6",     32'(a6), 32'h2);

    // Twenty alternating legal moves wrap both queues.
    do_reset();
    acks = 0; errs = 0; max_x = 0; max_o = 0;
    for (int i = 0; i < 10; i++) begin
      move(PX, 4'(xs[i % 4]));
      if (mv_ack) acks++;
      if (mv_err) errs++;
      if (pieces_of(brd, 2'b10) > max_x) max_x = pieces_of(brd, 2'b10);
      move(PO, 4'(os[i % 4]));
      if (mv_ack) acks++;
      if (mv_err) errs++;
      if (pieces_of(brd, 2'b01) > max_o) max_o = pieces_of(brd, 2'b01);
    end
    check("wrap_acks",   32'(acks), 32'd20);
    check("wrap_errs",   32'(errs), 32'd0);
    check("wrap_max_x",  32'(max_x), 32'd3);
    check("wrap_max_o",  32'(max_o), 32'd3);
    check("wrap_board",  32'(brd), 32'(board_of(9'b001000011, 9'b100001100)));
    check("wrap_hintv",  32'(hint_valid), 32'h1);
    check("wrap_hintc",  32'(hint_cell), 32'h6);
    check("wrap_winner", 32'(winner), 32'h0);

    // Reset wins over a simultaneous move.
    @(negedge clk);
    rst       = 1'b0;
    mv_valid  = 1'b1;
    mv_player = PX;
    mv_cell   = 4'd4;
    @(posedge clk);
    #1;
    check_reset_state("rstmv");
    rst      = 1'b1;
    mv_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
